// File: rtl/fc_feed_pkg.sv
// Shared definitions for the FC feed sequencer: state encoding, default sizes
// and the index-width helper used by the top level and the packing buffer.
package fc_feed_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_N_ELEM  = 8;
    localparam int unsigned FRAME_CNT_W = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_feed_buffer.sv
// N_ELEM x DATA_W packing register with indexed write and synchronous clear;
// word k appears at bits [k*DATA_W +: DATA_W] of frame.
module fc_feed_buffer
    import fc_feed_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N_ELEM = DEF_N_ELEM,
    parameter int unsigned IDX_W  = idx_width(DEF_N_ELEM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W*N_ELEM-1:0] frame
);

    logic [N_ELEM-1:0][DATA_W-1:0] words;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words <= '0;
        end else if (clear) begin
            words <= '0;
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    assign frame = words;

endmodule

// File: rtl/fc_feed_sequencer.sv
// Producer side of the FC layer: packs a feature stream into fc_input, runs the
// FC handshake and returns the result. Optional RUN watchdog: FC_FEED_TIMEOUT_EN.
module fc_feed_sequencer
    import fc_feed_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned N_ELEM      = DEF_N_ELEM,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    output logic [DATA_W*N_ELEM-1:0] fc_input,
    output logic                     fc_enable,
    input  logic                     fc_done,
    input  logic [DATA_W-1:0]        fc_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [FRAME_CNT_W-1:0]   frame_cnt,
    output logic                     err
);

    localparam int unsigned        IDX_W    = idx_width(N_ELEM);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_ELEM - 1);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_t           state, next_state;
    logic [IDX_W-1:0] idx;
    logic             run_first;
    logic             accept, frame_end, done_ok, timeout, out_fire;

    assign accept    = in_valid && in_ready;
    assign frame_end = accept && (in_last || idx == LAST_IDX);
    // The FC layer may still hold done from a previous job on the first RUN cycle.
    assign done_ok   = (state == ST_RUN) && !run_first && fc_done;
    assign out_fire  = (state == ST_OUT) && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FILL: if (frame_end)           next_state = ST_RUN;
            ST_RUN:  if (done_ok || timeout)  next_state = ST_OUT;
            ST_OUT:  if (out_ready)           next_state = ST_FILL;
            default:                          next_state = ST_FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_FILL);
        fc_enable = (state == ST_RUN);
        out_valid = (state == ST_OUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            run_first <= 1'b0;
            out_data  <= '0;
            frame_cnt <= '0;
        end else begin
            run_first <= (state == ST_FILL) && frame_end;
            if (out_fire) begin
                idx <= '0;
            end else if (accept) begin
                idx <= idx + 1'b1;
            end
            if (done_ok) begin
                out_data <= fc_result;
            end else if (timeout) begin
                out_data <= '0;
            end
            if (out_fire) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

`ifdef FC_FEED_TIMEOUT_EN
    localparam int unsigned      TMO_W    = idx_width(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts RUN cycles from 0; expiry lands on RUN cycle TIMEOUT_CYC+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            tmo_cnt <= (state == ST_RUN) ? tmo_cnt + 1'b1 : '0;
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

    assign timeout = (state == ST_RUN) && (tmo_cnt == TMO_LAST) && !done_ok;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    fc_feed_buffer #(
        .DATA_W (DATA_W),
        .N_ELEM (N_ELEM),
        .IDX_W  (IDX_W)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .clear   (out_fire),
        .wr_en   (accept),
        .wr_idx  (idx),
        .wr_data (in_data),
        .frame   (fc_input)
    );

endmodule

// File: tb/tb_fc_feed_sequencer.sv
// Randomized self-checking bench for fc_feed_sequencer; the timeout scenario
// is exercised only when FC_FEED_TIMEOUT_EN is defined.
module tb_fc_feed_sequencer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_ELEM = 8;
    localparam int unsigned VEC_W  = DATA_W * N_ELEM;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [VEC_W-1:0]  fc_input;
    logic              fc_enable;
    logic              fc_done;
    logic [DATA_W-1:0] fc_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       frame_cnt;
    logic              err;

    fc_feed_sequencer #(
        .DATA_W      (DATA_W),
        .N_ELEM      (N_ELEM),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .fc_input  (fc_input),
        .fc_enable (fc_enable),
        .fc_done   (fc_done),
        .fc_result (fc_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned       n_checks = 0;
    int unsigned       n_errors = 0;
    logic [DATA_W-1:0] feed_q[$];
    logic [VEC_W-1:0]  exp_vec;
    int unsigned       exp_cnt  = 0;
    logic              exp_err  = 1'b0;

    task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents feed_q with random gaps (spurious done during gaps); returns in RUN cycle 1.
    task automatic feed_frame(input bit use_last, input bit gaps);
        int unsigned i = 0;
        exp_vec = '0;
        foreach (feed_q[k]) exp_vec[k*DATA_W +: DATA_W] = feed_q[k];
        while (i < feed_q.size()) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                fc_done  = 1'($urandom_range(0, 1));
                fc_result = $urandom;
                step();
                fc_done  = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = feed_q[i];
            in_last  = use_last && (i == feed_q.size() - 1);
            check("in_ready_fill", in_ready, 1'b1);
            check("fc_enable_fill", fc_enable, 1'b0);
            step();
            i++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        check("fc_enable_rise", fc_enable, 1'b1);
        check("in_ready_run", in_ready, 1'b0);
        check("fc_input", fc_input, exp_vec);
    endtask

    task automatic finish_frame(input bit spur_first, input int unsigned lat, input int unsigned bp,
                                input logic [DATA_W-1:0] res);
        fc_done   = spur_first;
        fc_result = ~res;
        step();
        fc_done = 1'b0;
        check("no_capture_first", out_valid, 1'b0);
        check("fc_enable_hold", fc_enable, 1'b1);
        repeat (lat) step();
        check("fc_input_stable", fc_input, exp_vec);
        fc_done   = 1'b1;
        fc_result = res;
        step();
        fc_done   = 1'b0;
        fc_result = $urandom;
        check("out_valid", out_valid, 1'b1);
        check("out_data", out_data, res);
        check("fc_enable_fall", fc_enable, 1'b0);
        for (int c = 0; c < int'(bp); c++) begin
            out_ready = 1'b0;
            fc_done   = 1'($urandom_range(0, 1));
            step();
            fc_done = 1'b0;
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, res);
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt   = (exp_cnt + 1) % 65536;
        check("out_valid_clr", out_valid, 1'b0);
        check("in_ready_back", in_ready, 1'b1);
        check("frame_cnt", frame_cnt, exp_cnt);
        check("buf_cleared", fc_input, '0);
        check("err", err, exp_err);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        fc_done = 1'b0; fc_result = '0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fc_enable", fc_enable, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_frame_cnt", frame_cnt, '0);
        check("rst_err", err, 1'b0);
        check("rst_fc_input", fc_input, '0);
        @(posedge clk); #1 rst = 1'b1;
        step();

        // Full frame 1..8, result 36
        feed_q = {};
        for (int k = 1; k <= 8; k++) feed_q.push_back(DATA_W'(k));
        feed_frame(1'b0, 1'b0);
        finish_frame(1'b0, 2, 0, 32'd36);

        // Short frame 5,6,7 ending on in_last
        feed_q = {32'd5, 32'd6, 32'd7};
        feed_frame(1'b1, 1'b0);
        finish_frame(1'b0, 1, 0, 32'hDEAD_BEEF);

        // Backpressure for 10 cycles
        feed_q = {};
        for (int k = 0; k < 8; k++) feed_q.push_back($urandom);
        feed_frame(1'b0, 1'b0);
        finish_frame(1'b0, 3, 10, 32'h1234_5678);

        // Spurious done in FILL gaps and on the first RUN cycle
        feed_q = {32'hA, 32'hB, 32'hC, 32'hD};
        feed_frame(1'b1, 1'b1);
        finish_frame(1'b1, 0, 1, 32'hFFFF_FFF0);

        // Reset in the middle of RUN
        feed_q = {32'h11, 32'h22};
        feed_frame(1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async_fc_enable", fc_enable, 1'b0);
        check("async_out_valid", out_valid, 1'b0);
        check("async_out_data", out_data, '0);
        check("async_frame_cnt", frame_cnt, '0);
        check("async_fc_input", fc_input, '0);
        check("async_in_ready", in_ready, 1'b1);
        exp_cnt = 0;
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step();
        check("post_rst_enable", fc_enable, 1'b0);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            bit use_last = 1'($urandom_range(0, 1));
            int unsigned n = use_last ? $urandom_range(1, N_ELEM) : N_ELEM;
            feed_q = {};
            for (int k = 0; k < int'(n); k++) feed_q.push_back($urandom);
            feed_frame(use_last, 1'b1);
            finish_frame(1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 4), $urandom);
        end

`ifdef FC_FEED_TIMEOUT_EN
        begin
            int unsigned cyc = 0;
            // done on the expiry cycle (RUN cycle 21) must win
            feed_q = {32'h1, 32'h2};
            feed_frame(1'b1, 1'b0);
            finish_frame(1'b0, 19, 0, 32'h0BAD_F00D);

            feed_q = {};
            for (int k = 0; k < 8; k++) feed_q.push_back($urandom);
            feed_frame(1'b0, 1'b0);
            while (!out_valid && cyc < 100) begin
                step();
                cyc++;
            end
            check("timeout_latency", cyc, 21);
            check("timeout_err", err, 1'b1);
            check("timeout_data", out_data, '0);
            check("timeout_enable", fc_enable, 1'b0);
            exp_err   = 1'b1;
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            exp_cnt   = (exp_cnt + 1) % 65536;
            check("timeout_cnt", frame_cnt, exp_cnt);
            for (int f = 0; f < 2; f++) begin
                feed_q = {};
                for (int k = 0; k < 8; k++) feed_q.push_back($urandom);
                feed_frame(1'b0, 1'b1);
                finish_frame(1'b0, $urandom_range(0, 12), 1, $urandom);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
